muxn_stream: RTL and testbench
==============================

// Module: muxn_stream
// PURPOSE
//   Parametrised N-channel, W-bit streaming multiplexer. It is the registered, handshaked
//   successor of the combinational 2:1/4:1 mux tree.
//   - Merges CHANNELS valid/ready input streams into one output stream.
//   - Channel choice: explicit select (mode 0) or round-robin arbitration (mode 1).
//   - Sits between producers (e.g. ALU/memory result paths) and a single consumer port.
// PARAMETERS
//   N        32  data width per channel, bits
//   CHANNELS 4   number of input channels, >=2, power of 2
//   SW       $clog2(CHANNELS)  select/channel-index width (derived, not overridden)
// PORTS
//   clk        in   1           single clock, rising edge
//   rst_n      in   1           asynchronous, active-low reset
//   mode       in   1           0 = fixed select, 1 = round-robin
//   select     in   SW          channel index used in mode 0
//   in_data    in   CHANNELS*N  channel i = in_data[i*N +: N]
//   in_valid   in   CHANNELS    per-channel valid
//   in_ready   out  CHANNELS    per-channel ready (combinational)
//   out_data   out  N           registered output data
//   out_chan   out  SW          registered index of source channel of out_data
//   out_valid  out  1           registered output valid
//   out_ready  in   1           consumer ready
//   in_last    in   CHANNELS    [MUXN_LAST_EN only] end-of-packet per channel
//   out_last   out  1           [MUXN_LAST_EN only] registered end-of-packet
// BEHAVIOUR
//   - Reset (async assert, sync release): out_valid=0, out_data=0, out_chan=0, out_last=0.
//     Round-robin pointer rr_last=CHANNELS-1, so channel 0 has first priority. FSM=IDLE.
//   - load = !out_valid || out_ready. This is a single output register with full throughput.
//   - Grant (one-hot, at most one bit):
//     - mode 0: grant[select] = in_valid[select].
//     - mode 1: first i with in_valid[i]=1, searching from rr_last+1 upward, wrapping at
//       CHANNELS-1 -> 0.
//   - in_ready[i] = load && grant[i]. Ready never depends on in_valid of other channels in mode 0.
//   - Accept (in_valid[i] && in_ready[i]): next edge out_data<=in_data[i], out_chan<=i,
//     out_valid<=1. In mode 1, rr_last<=i.
//   - load with no grant: out_valid<=0 and out_data holds.
//   - !load: all outputs hold and in_ready=0. This is back-pressure.
//   - Latency: accepted beat appears on out_* exactly 1 cycle later.
//   - Simultaneous drain+fill: same edge, no bubble. Sustained 1 beat/cycle while out_ready=1.
//   - select/mode changes: honoured from the same cycle for the next grant. A registered beat
//     is never altered.
//   - rr_last changes only on an accepted beat in mode 1. Changing mode does not reset it.
//   - Reset mid-transfer: registered beat discarded, no in_ready asserted during reset.
// CONFIGURATION
//   - Macro MUXN_LAST_EN defined: in_last/out_last ports exist and the packet lock FSM is active.
//     - IDLE: grant per mode. A beat accepted with in_last[i]=0 -> LOCKED on chan i.
//     - LOCKED(i): grant forced to i regardless of mode/select/other valids. An accepted beat
//       with in_last[i]=1 -> IDLE.
//     - A single-beat packet (last=1 on first beat) stays IDLE.
//     - out_last <= in_last[i] on accept.
//   - Macro undefined: no in_last/out_last ports, no FSM. Arbitration is per beat.
// TESTING
//   1. Reset: rst_n=0 with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0. Release:
//      first accept on chan 0 (mode 1).
//   2. Mode 0, select=2, in_data ch2=0xA5A5_0002, out_ready=1 -> next cycle out_data=0xA5A5_0002,
//      out_chan=2. ch0/1/3 in_ready=0.
//   3. Mode 1, all valid, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3 with no
//      bubbles.
//   4. Back-pressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data stable, all
//      in_ready=0. out_ready=1 -> drain and refill on the same edge.
//   5. Mode 1, only ch3 valid, then ch1 joins -> grants 3,1,3,1. Wrap 3->0 skips invalid ch0.
//   6. MUXN_LAST_EN, mode 1: ch1 sends 3-beat packet (last on beat 3) while ch2 valid -> ch1,ch1,ch1
//      then ch2. out_last=1 only on the 3rd beat.

Source files
------------

// File: rtl/muxn_stream.sv
// ============================================================================
// Module      : muxn_stream
// Description : N-channel valid/ready stream mux with a single registered
//               output stage. The channel is chosen by explicit select or by
//               round-robin arbitration. Define MUXN_LAST_EN to add
//               in_last/out_last and hold the grant until a packet ends.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muxn_stream #(
  parameter  int N        = 32,
  parameter  int CHANNELS = 4,
  localparam int SW       = $clog2(CHANNELS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic [SW-1:0]         select,
  input  logic [CHANNELS*N-1:0] in_data,
  input  logic [CHANNELS-1:0]   in_valid,
  output logic [CHANNELS-1:0]   in_ready,
`ifdef MUXN_LAST_EN
  input  logic [CHANNELS-1:0]   in_last,
  output logic                  out_last,
`endif
  output logic [N-1:0]          out_data,
  output logic [SW-1:0]         out_chan,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam logic [SW-1:0] c_rr_init = SW'(CHANNELS - 1);

  logic          r_out_valid;
  logic [N-1:0]  r_out_data;
  logic [SW-1:0] r_out_chan;
  logic [SW-1:0] r_rr_last;

  logic          w_load;
  logic          w_any;
  logic          w_accept;
  logic [SW-1:0] w_idx;
  logic [SW-1:0] w_probe;
  logic [N-1:0]  w_sel_data;

`ifdef MUXN_LAST_EN
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;

  logic [0:0]    r_state;
  logic [SW-1:0] r_lock_chan;
  logic          r_out_last;
`endif

  assign w_load = !r_out_valid || out_ready;

  always_comb begin
    w_any   = 1'b0;
    w_idx   = '0;
    w_probe = '0;
    if (!mode) begin
      w_idx = select;
      w_any = in_valid[select];
    end else begin
      // Offset CHANNELS wraps back onto rr_last itself, so it is searched last.
      for (int k = 1; k <= CHANNELS; k++) begin
        w_probe = r_rr_last + SW'(k);
        if (!w_any && in_valid[w_probe]) begin
          w_any = 1'b1;
          w_idx = w_probe;
        end
      end
    end
`ifdef MUXN_LAST_EN
    if (r_state == S_LOCKED) begin
      w_idx = r_lock_chan;
      w_any = in_valid[r_lock_chan];
    end
`endif
  end

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_idx == SW'(i)) begin
        w_sel_data = in_data[i*N +: N];
      end
    end
  end

  assign w_accept = w_load && w_any;

  // Gating with rst_n keeps ready low while reset is held, even though load=1.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ready
    assign in_ready[i] = rst_n && w_accept && (w_idx == SW'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_rr_last   <= c_rr_init;
    end else if (w_load) begin
      r_out_valid <= w_any;
      if (w_any) begin
        r_out_data <= w_sel_data;
        r_out_chan <= w_idx;
        if (mode) begin
          r_rr_last <= w_idx;
        end
      end
    end
  end

`ifdef MUXN_LAST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_lock_chan <= '0;
      r_out_last  <= 1'b0;
    end else if (w_accept) begin
      r_out_last <= in_last[w_idx];
      case (r_state)
        S_IDLE: begin
          if (!in_last[w_idx]) begin
            r_state     <= S_LOCKED;
            r_lock_chan <= w_idx;
          end
        end
        default: begin
          if (in_last[w_idx]) begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign out_last = r_out_last;
`endif

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;

endmodule

`default_nettype wire

// File: tb/tb_muxn_stream.sv
// ============================================================================
// Module      : tb_muxn_stream
// Description : Self-checking bench for muxn_stream (4 x 32-bit). Channel i
//               carries data 0xA5A5_000i. MUXN_LAST_EN adds a packet test.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muxn_stream;

  localparam int N        = 32;
  localparam int CHANNELS = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  mode;
  logic [1:0]            select;
  logic [CHANNELS*N-1:0] in_data;
  logic [CHANNELS-1:0]   in_valid;
  logic [CHANNELS-1:0]   in_ready;
  logic [N-1:0]          out_data;
  logic [1:0]            out_chan;
  logic                  out_valid;
  logic                  out_ready;
`ifdef MUXN_LAST_EN
  logic [CHANNELS-1:0]   in_last;
  logic                  out_last;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign in_data = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};

  muxn_stream #(.N(N), .CHANNELS(CHANNELS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .select    (select),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef MUXN_LAST_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  valid;
    logic        oready;
    logic [3:0]  rdy;
    logic        ovalid;
    logic [1:0]  chan;
    logic [31:0] data;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(logic m, logic [1:0] s, logic [3:0] v, logic o,
                              logic [3:0] r, logic ov, logic [1:0] c, logic [31:0] d);
    vec_t t;
    t.mode = m; t.sel = s; t.valid = v; t.oready = o;
    t.rdy = r; t.ovalid = ov; t.chan = c; t.data = d;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    // mode, sel, valid, out_ready | in_ready, out_valid, out_chan, out_data
    tbl[0]  = mk(1, 0, 4'hF, 1, 4'b0001, 1, 0, 32'hA5A5_0000);
    tbl[1]  = mk(1, 0, 4'hF, 1, 4'b0010, 1, 1, 32'hA5A5_0001);
    tbl[2]  = mk(1, 0, 4'hF, 1, 4'b0100, 1, 2, 32'hA5A5_0002);
    tbl[3]  = mk(1, 0, 4'hF, 1, 4'b1000, 1, 3, 32'hA5A5_0003);
    tbl[4]  = mk(1, 0, 4'hF, 1, 4'b0001, 1, 0, 32'hA5A5_0000);
    tbl[5]  = mk(1, 0, 4'hF, 1, 4'b0010, 1, 1, 32'hA5A5_0001);
    tbl[6]  = mk(1, 0, 4'hF, 1, 4'b0100, 1, 2, 32'hA5A5_0002);
    tbl[7]  = mk(1, 0, 4'hF, 1, 4'b1000, 1, 3, 32'hA5A5_0003);
    tbl[8]  = mk(0, 2, 4'hF, 1, 4'b0100, 1, 2, 32'hA5A5_0002);
    tbl[9]  = mk(0, 1, 4'hF, 0, 4'b0000, 1, 2, 32'hA5A5_0002);
    tbl[10] = mk(0, 1, 4'hF, 0, 4'b0000, 1, 2, 32'hA5A5_0002);
    tbl[11] = mk(0, 1, 4'hF, 0, 4'b0000, 1, 2, 32'hA5A5_0002);
    tbl[12] = mk(0, 1, 4'hF, 1, 4'b0010, 1, 1, 32'hA5A5_0001);
    tbl[13] = mk(0, 1, 4'hD, 1, 4'b0000, 0, 0, 32'hA5A5_0001);
    tbl[14] = mk(1, 0, 4'h8, 1, 4'b1000, 1, 3, 32'hA5A5_0003);
    tbl[15] = mk(1, 0, 4'hA, 1, 4'b0010, 1, 1, 32'hA5A5_0001);
    tbl[16] = mk(1, 0, 4'hA, 1, 4'b1000, 1, 3, 32'hA5A5_0003);
    tbl[17] = mk(1, 0, 4'hA, 1, 4'b0010, 1, 1, 32'hA5A5_0001);
    tbl[18] = mk(1, 0, 4'h0, 0, 4'b0000, 1, 1, 32'hA5A5_0001);
    tbl[19] = mk(1, 0, 4'h0, 1, 4'b0000, 0, 0, 32'hA5A5_0001);

    rst_n     = 1'b0;
    mode      = 1'b1;
    select    = 2'd0;
    in_valid  = 4'hF;
    out_ready = 1'b1;
`ifdef MUXN_LAST_EN
    in_last   = 4'hF;
`endif

    // Reset held with every channel valid
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", out_data, 32'd0);
    chk("reset out_chan", 32'(out_chan), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      if (i != 0) @(negedge clk);
      mode      = tbl[i].mode;
      select    = tbl[i].sel;
      in_valid  = tbl[i].valid;
      out_ready = tbl[i].oready;
      #1;
      chk($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ovalid));
      if (tbl[i].ovalid) chk($sformatf("row%0d out_chan", i), 32'(out_chan), 32'(tbl[i].chan));
      chk($sformatf("row%0d out_data", i), out_data, tbl[i].data);
    end

    // Reset in the middle of a registered beat; rr pointer must restart at ch0
    @(negedge clk);
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("premid out_chan", 32'(out_chan), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst out_data", out_data, 32'd0);
    chk("midrst in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    chk("postrst in_ready", 32'(in_ready), 32'b0001);
    @(posedge clk);
    #1;
    chk("postrst out_valid", 32'(out_valid), 32'd1);
    chk("postrst out_chan", 32'(out_chan), 32'd0);

`ifdef MUXN_LAST_EN
    // ch1 three-beat packet competes with ch2; the lock must hold ch1 to its end
    begin
      logic [3:0] lastv [4];
      logic [1:0] expc  [4];
      logic       expl  [4];
      lastv[0] = 4'b0000; expc[0] = 2'd1; expl[0] = 1'b0;
      lastv[1] = 4'b0000; expc[1] = 2'd1; expl[1] = 1'b0;
      lastv[2] = 4'b0010; expc[2] = 2'd1; expl[2] = 1'b1;
      lastv[3] = 4'b0000; expc[3] = 2'd2; expl[3] = 1'b0;
      for (int b = 0; b < 4; b++) begin
        @(negedge clk);
        mode = 1'b1; in_valid = 4'b0110; out_ready = 1'b1; in_last = lastv[b];
        @(posedge clk);
        #1;
        chk($sformatf("pkt%0d out_chan", b), 32'(out_chan), 32'(expc[b]));
        chk($sformatf("pkt%0d out_last", b), 32'(out_last), 32'(expl[b]));
      end
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
